// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_unit
// Purpose  : HI/LO result registers plus an iterative restoring divider that
//            sits directly downstream of the combinational multiplier.
//            MULT captures the multiplier outputs in one cycle, MTHI/MTLO
//            write HI or LO directly, and DIV runs an N-cycle signed or
//            unsigned restoring division (remainder -> HI, quotient -> LO).
// Ports    :
//   clk      in   1  clock, all state updates on the rising edge
//   rst      in   1  synchronous active-high reset (aborts any division)
//   Start    in   1  issue request, accepted only while idle
//   Op       in   2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO
//   Signed   in   1  signed MULT/DIV
//   X        in   N  operand A / dividend / MTHI-MTLO data
//   Y        in   N  operand B / divisor
//   MulHi    in   N  multiplier high product half (same cycle as Start)
//   MulLo    in   N  multiplier low product half
//   MulOv    in   1  multiplier overflow
//   HI       out  N  product high / remainder
//   LO       out  N  product low / quotient
//   Busy     out  1  division in progress, issue must stall
//   Done     out  1  one-cycle pulse, HI/LO just updated by an accepted op
//   Ov       out  1  overflow flag of the last MULT/DIV
//   DivZero  out  1  last DIV had a zero divisor
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Start,
  input  logic [1:0]   Op,
  input  logic         Signed,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic [N-1:0] MulHi,
  input  logic [N-1:0] MulLo,
  input  logic         MulOv,
  output logic [N-1:0] HI,
  output logic [N-1:0] LO,
  output logic         Busy,
  output logic         Done,
  output logic         Ov,
  output logic         DivZero
);

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  localparam int CW = $clog2(N);

  localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  MIN_N    = {1'b1, {(N-1){1'b0}}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;        // remaining iterations minus one
  logic [N-1:0]  rem;        // restored partial remainder, always < divisor
  logic [N-1:0]  quo;        // dividend bits shift out MSB-first, quotient bits shift in
  logic [N-1:0]  divisor;    // divisor magnitude
  logic          q_neg;      // quotient sign = sign(X) ^ sign(Y)
  logic          r_neg;      // remainder takes the dividend's sign
  logic          ov_pend;    // most-negative / -1 case, reported at completion

  // Operand magnitudes; the most negative value negates to itself, which is
  // exactly its correct unsigned magnitude.
  logic         x_neg;
  logic         y_neg;
  logic [N-1:0] x_mag;
  logic [N-1:0] y_mag;
  logic         y_zero;
  logic         div_min_ov;

  assign x_neg      = Signed & X[N-1];
  assign y_neg      = Signed & Y[N-1];
  assign x_mag      = x_neg ? (~X + ONE_N) : X;
  assign y_mag      = y_neg ? (~Y + ONE_N) : Y;
  assign y_zero     = (Y == '0);
  assign div_min_ov = Signed & (X == MIN_N) & (&Y);

  // One restoring step: bring down the next dividend bit into an N+1-bit
  // partial remainder and trial-subtract the divisor. The extra top bit of
  // the difference is the borrow.
  logic [N:0]   part;
  logic [N+1:0] trial;
  logic         borrow;
  logic         unused_trial_bit;

  assign part             = {rem, quo[N-1]};
  assign trial            = {1'b0, part} - {2'b00, divisor};
  assign borrow           = trial[N+1];
  assign unused_trial_bit = trial[N];

  // Sign fix-up of the unsigned results.
  logic [N-1:0] q_fix;
  logic [N-1:0] r_fix;

  assign q_fix = q_neg ? (~quo + ONE_N) : quo;
  assign r_fix = r_neg ? (~rem + ONE_N) : rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      ov_pend <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Ov      <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            case (Op)
              OP_MULT: begin
                HI      <= MulHi;
                LO      <= MulLo;
                Ov      <= MulOv;
                DivZero <= 1'b0;
                Done    <= 1'b1;
              end
              OP_MTHI: begin
                HI   <= X;
                Done <= 1'b1;
              end
              OP_MTLO: begin
                LO   <= X;
                Done <= 1'b1;
              end
              OP_DIV: begin
                if (y_zero) begin
                  // Divide by zero completes immediately with a defined result.
                  HI      <= X;
                  LO      <= '1;
                  DivZero <= 1'b1;
                  Ov      <= 1'b0;
                  Done    <= 1'b1;
                end else begin
                  state   <= S_ITER;
                  Busy    <= 1'b1;
                  cnt     <= CNT_INIT;
                  rem     <= '0;
                  quo     <= x_mag;
                  divisor <= y_mag;
                  q_neg   <= x_neg ^ y_neg;
                  r_neg   <= x_neg;
                  ov_pend <= div_min_ov;
                end
              end
              default: ;
            endcase
          end
        end

        S_ITER: begin
          rem <= borrow ? part[N-1:0] : trial[N-1:0];
          quo <= {quo[N-2:0], ~borrow};
          if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        S_FIX: begin
          HI      <= r_fix;
          LO      <= q_fix;
          Ov      <= ov_pend;
          DivZero <= 1'b0;
          Busy    <= 1'b0;
          Done    <= 1'b1;
          state   <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
